// File: rtl/mult_control_param_if.sv
// ----------------------------------------------------------------------------
// mult_control_param_if
// Handshake and control bundle between the shift-add multiplier sequencer and
// its environment (switch/run logic on one side, X/A/B datapath on the other).
//
// Parameters
//   WIDTH         operand width; sets the width of Iter ($clog2(WIDTH))
//
// Signals
//   Run           start request, level, held until the operation finishes
//   ClearA_LoadB  IDLE: load B from switches; HALT: clear X/A
//   M             current multiplier LSB (B[0])
//   Signed_In     1 = two's-complement multiply, sampled once per operation
//   Shift_En      shift X/A/B right one bit
//   Ld_A          load adder result into X/A
//   Ld_B          load B register
//   Clear_XA      clear X and A
//   Sub           adder subtracts instead of adding
//   Busy          operation in progress
//   Done          result ready, waiting for Run to drop
//   Iter          current iteration index
//
// Modports
//   master        environment side (drives requests, observes controls)
//   slave         sequencer side
// ----------------------------------------------------------------------------
interface mult_control_param_if #(
    parameter int WIDTH = 8
);
    localparam int CW = $clog2(WIDTH);

    logic          Run;
    logic          ClearA_LoadB;
    logic          M;
    logic          Signed_In;
    logic          Shift_En;
    logic          Ld_A;
    logic          Ld_B;
    logic          Clear_XA;
    logic          Sub;
    logic          Busy;
    logic          Done;
    logic [CW-1:0] Iter;

    modport master (
        output Run, ClearA_LoadB, M, Signed_In,
        input  Shift_En, Ld_A, Ld_B, Clear_XA, Sub, Busy, Done, Iter
    );

    modport slave (
        input  Run, ClearA_LoadB, M, Signed_In,
        output Shift_En, Ld_A, Ld_B, Clear_XA, Sub, Busy, Done, Iter
    );
endinterface

// File: rtl/mult_control_param.sv
// ----------------------------------------------------------------------------
// mult_control_param
// Parametrised control FSM for a shift-add multiplier datapath. Runs WIDTH
// add/shift iterations driven by an iteration counter, supports a per-operation
// signed/unsigned mode (last partial product is subtracted in signed mode) and
// an optional fast path that skips the add cycle when the multiplier bit is 0.
//
// Parameters
//   WIDTH      operand width = number of iterations, 2..32
//   SKIP_ZERO  1: an iteration with M=0 is a single shift cycle
//
// Ports
//   Clk        system clock, all state on rising edge
//   Reset_n    asynchronous active-low reset
//   bus        mult_control_param_if.slave (requests in, datapath controls
//              and Busy/Done/Iter status out)
// ----------------------------------------------------------------------------
module mult_control_param #(
    parameter int WIDTH     = 8,
    parameter bit SKIP_ZERO = 1'b0
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    mult_control_param_if.slave   bus
);
    localparam int CW = $clog2(WIDTH);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] PREP  = 3'd1;
    localparam logic [2:0] ADD   = 3'd2;
    localparam logic [2:0] SHIFT = 3'd3;
    localparam logic [2:0] HALT  = 3'd4;

    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    logic [2:0]    state;
    logic [2:0]    state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          sgn;
    logic          sgn_nxt;
    logic          last_iter;

    assign last_iter = (cnt == LAST_ITER);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= IDLE;
            cnt   <= '0;
            sgn   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            sgn   <= sgn_nxt;
        end
    end

    // Run is only looked at in IDLE and HALT, so dropping it mid-operation
    // never aborts; HALT waits for Run low to avoid an automatic restart.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        sgn_nxt   = sgn;
        case (state)
            IDLE: begin
                if (bus.Run) state_nxt = PREP;
            end
            PREP: begin
                cnt_nxt   = '0;
                sgn_nxt   = bus.Signed_In;
                state_nxt = ADD;
            end
            ADD: begin
                if (bus.M || !SKIP_ZERO) begin
                    state_nxt = SHIFT;
                end else if (last_iter) begin
                    state_nxt = HALT;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            SHIFT: begin
                if (last_iter) begin
                    state_nxt = HALT;
                end else begin
                    cnt_nxt   = cnt + CW'(1);
                    state_nxt = ADD;
                end
            end
            HALT: begin
                if (!bus.Run) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // With the skip fast path, a zero multiplier bit turns the ADD cycle into
    // the shift itself, so Ld_A and Shift_En are still never both high.
    always_comb begin
        bus.Shift_En = 1'b0;
        bus.Ld_A     = 1'b0;
        bus.Ld_B     = 1'b0;
        bus.Clear_XA = 1'b0;
        bus.Sub      = 1'b0;
        bus.Busy     = 1'b0;
        bus.Done     = 1'b0;
        case (state)
            IDLE: begin
                bus.Ld_B = bus.ClearA_LoadB;
            end
            PREP: begin
                bus.Clear_XA = 1'b1;
                bus.Busy     = 1'b1;
            end
            ADD: begin
                bus.Busy = 1'b1;
                if (bus.M) begin
                    bus.Ld_A = 1'b1;
                    bus.Sub  = sgn && last_iter;
                end else if (SKIP_ZERO) begin
                    bus.Shift_En = 1'b1;
                end
            end
            SHIFT: begin
                bus.Shift_En = 1'b1;
                bus.Busy     = 1'b1;
            end
            HALT: begin
                bus.Done     = 1'b1;
                bus.Clear_XA = bus.ClearA_LoadB;
            end
            default: ;
        endcase
    end

    assign bus.Iter = cnt;
endmodule

// File: tb/tb_mult_control_param.sv
// ----------------------------------------------------------------------------
// tb_mult_control_param
// Self-checking bench for mult_control_param. Five instances cover WIDTH 8/16/2
// with and without the skip fast path. A small B-register model feeds M from
// the multiplier as Shift_En pulses occur; the expected per-cycle control
// trace is derived from the multiplier bits and the signed flag.
// Output vector layout: {Shift_En, Ld_A, Ld_B, Clear_XA, Sub, Busy, Done,
// Iter[4:0]}.
// ----------------------------------------------------------------------------
module tb_mult_control_param;
    localparam int ND = 5;
    localparam int WS [ND] = '{8, 8, 16, 2, 2};
    localparam bit SK [ND] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

    logic clk = 1'b0;
    logic rst_n;
    logic [ND-1:0] run;
    logic [ND-1:0] clr_ld;
    logic [ND-1:0] m_bit;
    logic [ND-1:0] sgn_in;
    logic [ND-1:0][11:0] out_vec;

    int tests_run    = 0;
    int tests_failed = 0;
    logic [31:0] b_reg [ND];
    int prev_iter [ND];

    always #5 clk = ~clk;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        mult_control_param_if #(.WIDTH(WS[g])) bus ();

        mult_control_param #(.WIDTH(WS[g]), .SKIP_ZERO(SK[g])) dut (
            .Clk     (clk),
            .Reset_n (rst_n),
            .bus     (bus.slave)
        );

        assign bus.Run          = run[g];
        assign bus.ClearA_LoadB = clr_ld[g];
        assign bus.M            = m_bit[g];
        assign bus.Signed_In    = sgn_in[g];
        assign out_vec[g] = {bus.Shift_En, bus.Ld_A, bus.Ld_B, bus.Clear_XA,
                             bus.Sub, bus.Busy, bus.Done, 5'(bus.Iter)};
    end

    function automatic logic [11:0] pack_exp(bit sh, bit ld_a, bit ld_b, bit clr,
                                             bit sub, bit busy, bit done, int iter);
        return {sh, ld_a, ld_b, clr, sub, busy, done, 5'(iter)};
    endfunction

    task automatic check_val(string tag, int d, logic [31:0] obs, logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("[TB] FAIL %s dut%0d: got 0x%0h expected 0x%0h", tag, d, obs, exp);
        end
    endtask

    // Presents M from the B-register model, then compares all outputs.
    task automatic check_output(int d, logic [11:0] exp, string tag,
                                output logic [11:0] obs);
        m_bit[d] = b_reg[d][0];
        #1;
        obs = out_vec[d];
        check_val(tag, d, 32'(obs), 32'(exp));
    endtask

    task automatic step(int d, logic [11:0] obs);
        @(posedge clk);
        #1;
        if (obs[11]) b_reg[d] = b_reg[d] >> 1;
    endtask

    // One full operation on instance d. abort_at >= 0 pulls Reset_n low at
    // that trace position and leaves Run high so the next call restarts.
    task automatic apply_stimulus(int d, logic [31:0] mult, bit sgn, int hold, int abort_at);
        int w;
        bit sk;
        int ones;
        int exp_lat;
        int busy_cycles;
        logic [11:0] trace [$];
        logic [11:0] obs;

        w = WS[d];
        sk = SK[d];
        ones = 0;
        busy_cycles = 0;
        trace.push_back(pack_exp(0, 0, 0, 1, 0, 1, 0, prev_iter[d]));
        for (int i = 0; i < w; i++) begin
            bit b;
            b = mult[i];
            ones += int'(b);
            if (b || !sk) begin
                trace.push_back(pack_exp(0, b, 0, 0, b && sgn && (i == w - 1), 1, 0, i));
                trace.push_back(pack_exp(1, 0, 0, 0, 0, 1, 0, i));
            end else begin
                trace.push_back(pack_exp(1, 0, 0, 0, 0, 1, 0, i));
            end
        end
        exp_lat = sk ? (1 + w + ones) : (2 * w + 1);

        b_reg[d]  = mult;
        sgn_in[d] = sgn;
        clr_ld[d] = 1'b0;
        run[d]    = 1'b1;
        @(posedge clk);
        #1;

        foreach (trace[k]) begin
            if (k == abort_at) begin
                run[d]    = 1'b1;
                clr_ld[d] = 1'($urandom_range(0, 1));
                rst_n     = 1'b0;
                check_output(d, pack_exp(0, 0, clr_ld[d], 0, 0, 0, 0, 0), "reset_abort", obs);
                @(negedge clk);
                rst_n = 1'b1;
                for (int j = 0; j < ND; j++) prev_iter[j] = 0;
                check_output(d, pack_exp(0, 0, clr_ld[d], 0, 0, 0, 0, 0), "after_reset", obs);
                return;
            end
            run[d]    = 1'($urandom_range(0, 1));
            clr_ld[d] = 1'($urandom_range(0, 1));
            if (k > 0) sgn_in[d] = 1'($urandom_range(0, 1));
            check_output(d, trace[k], "op_trace", obs);
            if (obs[6]) busy_cycles++;
            step(d, obs);
        end

        for (int h = 0; h <= hold; h++) begin
            run[d]    = (h < hold);
            clr_ld[d] = 1'($urandom_range(0, 1));
            check_output(d, pack_exp(0, 0, 0, clr_ld[d], 0, 0, 1, w - 1), "halt", obs);
            step(d, obs);
        end
        check_val("latency", d, 32'(busy_cycles), 32'(exp_lat));
        prev_iter[d] = w - 1;

        for (int i = 0; i < 2; i++) begin
            clr_ld[d] = 1'(i);
            check_output(d, pack_exp(0, 0, clr_ld[d], 0, 0, 0, 0, w - 1), "idle", obs);
            step(d, obs);
        end
        clr_ld[d] = 1'b0;
    endtask

    initial begin
        logic [11:0] obs;

        rst_n  = 1'b0;
        run    = '0;
        clr_ld = '0;
        m_bit  = '0;
        sgn_in = '0;
        for (int d = 0; d < ND; d++) begin
            b_reg[d]     = '0;
            prev_iter[d] = 0;
        end
        #2;

        for (int d = 0; d < ND; d++) begin
            clr_ld[d] = 1'b1;
            check_output(d, pack_exp(0, 0, 1, 0, 0, 0, 0, 0), "reset_ldb1", obs);
            clr_ld[d] = 1'b0;
            check_output(d, pack_exp(0, 0, 0, 0, 0, 0, 0, 0), "reset_ldb0", obs);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        apply_stimulus(0, $urandom, 1'b0, 1, -1);
        apply_stimulus(0, 32'h0000_00FF, 1'b1, 0, -1);
        apply_stimulus(0, 32'h0000_00FF, 1'b0, 20, -1);
        apply_stimulus(1, 32'h0000_0012, 1'b0, 2, -1);
        apply_stimulus(1, 32'h0000_00FF, 1'b1, 0, -1);
        apply_stimulus(2, 32'h0000_FFFF, 1'b1, 1, -1);
        apply_stimulus(3, 32'h0000_0003, 1'b1, 1, -1);
        apply_stimulus(4, 32'h0000_0002, 1'b0, 1, -1);

        for (int i = 0; i < 4 * ND; i++) begin
            apply_stimulus(i % ND, $urandom, 1'($urandom_range(0, 1)),
                           $urandom_range(0, 3), -1);
        end

        // Trace index 8 is the SHIFT cycle of iteration 3 for WIDTH=8 without skip.
        apply_stimulus(0, $urandom, 1'b0, 0, 8);
        apply_stimulus(0, $urandom, 1'b1, 1, -1);
        apply_stimulus(3, $urandom, 1'b0, 0, -1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
